pipe_chain: RTL

- Parametrised, elastic N-stage register pipeline with a valid/ready handshake on both ends.
- Adds the following, which the plain enable-only flop chain does not have:
  - per-stage backpressure with bubble collapsing;
  - per-stage flush vector (generalises "reset first stage / reset the rest");
  - global stall;
  - occupancy count.
- Used between core pipeline stages and memory-side queues where stages must stall and be squashed independently.

---
 rtl/pipe_pkg.sv | 10 +
 rtl/pipe_chain_if.sv | 22 ++
 rtl/pipe_chain_stage.sv | 50 +++++
 rtl/pipe_chain.sv | 88 ++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_chain elastic register pipeline.
// Imported by the stage and the top so both agree on the occupancy width.
package pipe_pkg;

  // Number of bits needed to count from 0 to depth without wrapping.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_chain_if.sv
// Valid/ready handshake bundle for both ends of pipe_chain.
// The master modport is the environment side; the slave modport is the pipe side.
interface pipe_chain_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_chain_stage.sv
// One pipe_chain register stage: a valid flag plus payload.
// Priority is flush > incoming move > datum leaving > hold.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             move_in,
  input  logic             leave,
  input  logic             flush,
  input  logic [WIDTH-1:0] payload,
  output logic             valid,
  output logic             valid_nxt,
  output logic [WIDTH-1:0] data
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t st_q;

  // NOTE: valid_nxt gets its hold value first, so no branch can leave it unassigned and infer a latch.
  always_comb begin
    valid_nxt = st_q.valid;
    if (flush)        valid_nxt = 1'b0;
    else if (move_in) valid_nxt = 1'b1;
    else if (leave)   valid_nxt = 1'b0;
  end

  // NOTE: data is reset as well as valid so out_data shows RESET_VALUE straight out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q.valid <= 1'b0;
      st_q.data  <= RESET_VALUE;
    end else begin
      // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
      st_q.valid <= valid_nxt;
      if (!flush && move_in) st_q.data <= payload;
    end
  end

  assign valid = st_q.valid;
  assign data  = st_q.data;

endmodule

// File: rtl/pipe_chain.sv
// Elastic DEPTH-stage register pipeline with valid/ready on both ends,
// bubble collapsing, per-stage flush, global stall and registered occupancy.
module pipe_chain
  import pipe_pkg::*;
#(
  parameter int               DEPTH       = 3,
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [DEPTH-1:0]          flush,
  pipe_chain_if.slave               bus,
  output logic [cnt_w(DEPTH)-1:0]   occupancy
);

  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] move;
  logic [DEPTH-1:0] leave;
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] valid_nxt;
  logic [WIDTH-1:0] data    [DEPTH];
  logic [WIDTH-1:0] payload [DEPTH];
  logic             out_fire;
  logic [CW-1:0]    occ_nxt;

  // Ready ripples back from the output using raw valid; flush does not open a slot early.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = enable & (~valid[i] | rdy[i+1]);
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = valid[DEPTH-1] & ~flush[DEPTH-1];
  assign bus.out_data  = data[DEPTH-1];
  assign out_fire      = bus.out_valid & bus.out_ready & enable;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign move[i]    = bus.in_valid & rdy[0];
      assign payload[i] = bus.in_data;
    end else begin : g_body
      assign move[i]    = valid[i-1] & ~flush[i-1] & rdy[i];
      assign payload[i] = data[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      assign leave[i] = out_fire;
    end else begin : g_mid
      assign leave[i] = move[i+1];
    end

    pipe_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk       (clk),
      .reset_n   (reset_n),
      .move_in   (move[i]),
      .leave     (leave[i]),
      .flush     (flush[i]),
      .payload   (payload[i]),
      .valid     (valid[i]),
      .valid_nxt (valid_nxt[i]),
      .data      (data[i])
    );
  end

  // Count the next-state valids so occupancy lands on the same edge as the stages.
  always_comb begin
    occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_nxt = occ_nxt + CW'(valid_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) occupancy <= '0;
    else          occupancy <= occ_nxt;
  end

endmodule
